// File: rtl/config_frame_loader_if.sv
// Bus bundle between the bitstream source and the configuration-frame loader:
// write-word stream in, assembled frame / column strobes and status out.
interface config_frame_loader_if #(
    parameter int unsigned NumberOfRows = 4,
    parameter int unsigned NumberOfCols = 8
);
    logic [31:0]                 WriteData;
    logic                        WriteStrobe;
    logic [32*NumberOfRows-1:0]  FrameData;
    logic [4:0]                  FrameIndex;
    logic [NumberOfCols-1:0]     ColStrobe;
    logic                        Active;
    logic                        Configured;
    logic                        AddrError;

    modport master (
        output WriteData, WriteStrobe,
        input  FrameData, FrameIndex, ColStrobe, Active, Configured, AddrError
    );

    modport slave (
        input  WriteData, WriteStrobe,
        output FrameData, FrameIndex, ColStrobe, Active, Configured, AddrError
    );
endinterface

// File: rtl/config_frame_loader.sv
// Configuration-write engine: turns a sync/address/data word stream into
// assembled frames plus a one-cycle one-hot column write strobe.
module config_frame_loader #(
    parameter int unsigned NumberOfRows    = 4,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NumberOfCols    = 8,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1,
    parameter logic [31:0] DesyncWord      = 32'hFAB0_FAB0
) (
    input logic                 CLK,
    input logic                 resetn,
    config_frame_loader_if.slave bus
);

    localparam int unsigned     RowW    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]                              state;
    logic [7:0]                              col;
    logic [4:0]                              frm;
    logic [RowW-1:0]                         row;
    logic                                    discard;
    logic [FrameBitsPerRow*NumberOfRows-1:0] frame_data;
    logic [4:0]                              frame_index;
    logic [NumberOfCols-1:0]                 col_strobe;
    logic                                    active;
    logic                                    configured;
    logic                                    addr_error;

    logic                                    addr_bad;
    logic [NumberOfCols-1:0]                 col_onehot;

    always_comb begin
        addr_bad = ({24'd0, bus.WriteData[31:24]} >= NumberOfCols) ||
                   ({27'd0, bus.WriteData[4:0]} >= MaxFramesPerCol);
        col_onehot = '0;
        for (int unsigned c = 0; c < NumberOfCols; c++) begin
            col_onehot[c] = ({24'd0, col} == c);
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            col         <= '0;
            frm         <= '0;
            row         <= '0;
            discard     <= 1'b0;
            frame_data  <= '0;
            frame_index <= '0;
            col_strobe  <= '0;
            active      <= 1'b0;
            configured  <= 1'b0;
            addr_error  <= 1'b0;
        end else begin
            col_strobe <= '0;
            if (bus.WriteStrobe) begin
                case (state)
                    IDLE: begin
                        if (bus.WriteData == SyncWord) begin
                            state      <= ADDR;
                            active     <= 1'b1;
                            configured <= 1'b0;
                            addr_error <= 1'b0;
                        end
                    end
                    ADDR: begin
                        if (bus.WriteData == DesyncWord) begin
                            state      <= IDLE;
                            active     <= 1'b0;
                            configured <= 1'b1;
                        end else if (bus.WriteData != SyncWord) begin
                            col     <= bus.WriteData[31:24];
                            frm     <= bus.WriteData[4:0];
                            row     <= '0;
                            discard <= addr_bad;
                            if (addr_bad) begin
                                addr_error <= 1'b1;
                            end
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        frame_data[row*FrameBitsPerRow +: FrameBitsPerRow] <= bus.WriteData;
                        row <= row + 1'b1;
                        // Strobe registers on the same edge that captures the last row,
                        // so FrameData is complete in the strobe cycle.
                        if (row == LastRow) begin
                            state <= ADDR;
                            if (!discard) begin
                                col_strobe  <= col_onehot;
                                frame_index <= frm;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.FrameData  = frame_data;
    assign bus.FrameIndex = frame_index;
    assign bus.ColStrobe  = col_strobe;
    assign bus.Active     = active;
    assign bus.Configured = configured;
    assign bus.AddrError  = addr_error;

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: expected frames are queued as the
// stream is driven and matched against every ColStrobe pulse.
module tb_config_frame_loader;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    typedef struct {
        logic [7:0]   cs;
        logic [4:0]   fi;
        logic [127:0] fd;
    } exp_t;

    logic        CLK = 1'b0;
    logic        resetn;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned strobe_cnt = 0;
    int unsigned exp_strobes = 0;
    int unsigned prev_cyc = 0;
    int unsigned last_gap = 0;
    exp_t        sb[$];
    exp_t        e;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    config_frame_loader_if #(.NumberOfRows(4), .NumberOfCols(8)) bus();

    config_frame_loader #(
        .NumberOfRows(4),
        .FrameBitsPerRow(32),
        .NumberOfCols(8),
        .MaxFramesPerCol(20),
        .SyncWord(SYNC),
        .DesyncWord(DESYNC)
    ) dut (
        .CLK(CLK),
        .resetn(resetn),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.ColStrobe !== '0) begin
            strobe_cnt++;
            last_gap = cyc - prev_cyc;
            prev_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 128'(bus.ColStrobe), 128'd0);
            end else begin
                e = sb.pop_front();
                check("col_strobe", 128'(bus.ColStrobe), 128'(e.cs));
                check("frame_index", 128'(bus.FrameIndex), 128'(e.fi));
                check("frame_data", bus.FrameData, e.fd);
            end
        end
    end

    task automatic send(input logic [31:0] w);
        bus.WriteData   = w;
        bus.WriteStrobe = 1'b1;
        @(posedge CLK);
        #1;
        bus.WriteStrobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    // live=0 means the loader is not expected to be in a session.
    task automatic send_frame(input logic [7:0] c, input logic [4:0] f,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int gap, input bit live);
        exp_t x;
        send({c, 19'd0, f});
        if (gap > 0) idle(gap);
        send(d0);
        if (gap > 0) idle(gap);
        send(d1);
        if (gap > 0) idle(gap);
        send(d2);
        if (gap > 0) idle(gap);
        if (live && c < 8 && f < 20) begin
            x.cs = 8'd1 << c;
            x.fi = f;
            x.fd = {d3, d2, d1, d0};
            sb.push_back(x);
            exp_strobes++;
        end
        send(d3);
    endtask

    initial begin
        resetn          = 1'b0;
        bus.WriteData   = '0;
        bus.WriteStrobe = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_active", 128'(bus.Active), 128'd0);
        check("rst_configured", 128'(bus.Configured), 128'd0);
        check("rst_addr_error", 128'(bus.AddrError), 128'd0);
        check("rst_col_strobe", 128'(bus.ColStrobe), 128'd0);
        check("rst_frame_index", 128'(bus.FrameIndex), 128'd0);
        check("rst_frame_data", bus.FrameData, 128'd0);
        @(negedge CLK);
        resetn = 1'b1;
        idle(2);

        // basic frame
        send(SYNC);
        send_frame(8'd3, 5'd5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0, 1);
        settle();
        check("t1_active", 128'(bus.Active), 128'd1);
        check("t1_strobes", 128'(strobe_cnt), 128'd1);

        // desync, then a frame while idle must be ignored
        send(DESYNC);
        settle();
        check("t2_active", 128'(bus.Active), 128'd0);
        check("t2_configured", 128'(bus.Configured), 128'd1);
        send_frame(8'd1, 5'd0, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 0, 0);
        idle(3);
        check("t2_idle_strobes", 128'(strobe_cnt), 128'd1);
        check("t2_idle_active", 128'(bus.Active), 128'd0);

        // bad column, re-sync in ADDR, boundary frames
        send(SYNC);
        settle();
        check("t3_configured_clr", 128'(bus.Configured), 128'd0);
        send_frame(8'd9, 5'd2, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 0, 1);
        settle();
        check("t3_addr_error", 128'(bus.AddrError), 128'd1);
        check("t3_active", 128'(bus.Active), 128'd1);
        send(SYNC);
        settle();
        check("t3_resync_keeps_err", 128'(bus.AddrError), 128'd1);
        send_frame(8'd2, 5'd19, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 0, 1);
        send_frame(8'd0, 5'd20, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 0, 1);
        settle();
        check("t3_strobes", 128'(strobe_cnt), 128'd2);
        send(DESYNC);

        // back-to-back frames with WriteStrobe held high
        send(SYNC);
        send_frame(8'd0, 5'd0, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 0, 1);
        send_frame(8'd7, 5'd1, 32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, 0, 1);
        settle();
        check("t4_addr_error_clr", 128'(bus.AddrError), 128'd0);
        check("t4_b2b_gap", 128'(last_gap), 128'd5);
        check("t4_strobes", 128'(strobe_cnt), 128'd4);
        send_frame(8'd1, 5'd12, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 2, 1);
        settle();
        check("t4_gap_strobes", 128'(strobe_cnt), 128'd5);

        // sync/desync values inside DATA are plain data
        send_frame(8'd4, 5'd7, DESYNC, SYNC, 32'hCAFE_F00D, 32'h0, 0, 1);
        send_frame(8'd5, 5'd3, 32'h1, 32'h2, 32'h3, 32'h4, 0, 1);
        settle();
        check("t5_active", 128'(bus.Active), 128'd1);
        check("t5_strobes", 128'(strobe_cnt), 128'd7);

        // reset mid-frame
        send({8'd6, 24'd1});
        send(32'h7777_0000);
        send(32'h7777_0001);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_active", 128'(bus.Active), 128'd0);
        check("t6_rst_strobe", 128'(bus.ColStrobe), 128'd0);
        check("t6_rst_frame_data", bus.FrameData, 128'd0);
        check("t6_rst_addr_error", 128'(bus.AddrError), 128'd0);
        repeat (2) @(negedge CLK);
        resetn = 1'b1;
        idle(4);
        check("t6_no_strobe", 128'(strobe_cnt), 128'd7);
        send(SYNC);
        send_frame(8'd6, 5'd1, 32'h9999_0000, 32'h9999_0001, 32'h9999_0002, 32'h9999_0003, 0, 1);
        settle();
        check("t6_after_strobes", 128'(strobe_cnt), 128'd8);
        check("t6_after_active", 128'(bus.Active), 128'd1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
        check("sb_drained", 128'(sb.size()), 128'd0);
        check("strobe_total", 128'(strobe_cnt), 128'(exp_strobes));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
